// File: rtl/sip_pkg.sv
// Shared types and helpers for the SipHash round datapath: FSM states,
// default rotation constants for SipHash (64-bit) and HalfSipHash (32-bit).
package sip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_B,
    DONE
  } sip_state_t;

  localparam int unsigned ROT64_A1 = 13;
  localparam int unsigned ROT64_A3 = 16;
  localparam int unsigned ROT64_B1 = 17;
  localparam int unsigned ROT64_B3 = 21;

  localparam int unsigned ROT32_A1 = 5;
  localparam int unsigned ROT32_A3 = 8;
  localparam int unsigned ROT32_B1 = 13;
  localparam int unsigned ROT32_B3 = 7;

  // Circular rotate-left of the low w bits of x (w <= 64); bits above w are zero.
  function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n,
                                       input int unsigned w);
    logic [63:0] mask;
    logic [63:0] xm;
    int unsigned sh;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    sh   = n % w;
    return ((xm << sh) | (xm >> (w - sh))) & mask;
  endfunction

endpackage

// File: rtl/sip_half_round_comb.sv
// Generic SipHash half-round on (a,b,c,d); purely combinational.
// Phase A maps (v0,v1,v2,v3), phase B maps (v2,v1,v0,v3).
module sip_half_round_comb
  import sip_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned ROT_1 = 13,
  parameter int unsigned ROT_3 = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_new,
  output logic [WIDTH-1:0] b_new,
  output logic [WIDTH-1:0] c_new,
  output logic [WIDTH-1:0] d_new
);

  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] sum_cd;

  assign sum_ab = a + b;
  assign sum_cd = c + d;

  assign b_new = WIDTH'(rotl(64'(b), ROT_1, WIDTH)) ^ sum_ab;
  assign a_new = WIDTH'(rotl(64'(sum_ab), WIDTH / 2, WIDTH));
  assign c_new = sum_cd;
  assign d_new = WIDTH'(rotl(64'(d), ROT_3, WIDTH)) ^ sum_cd;

endmodule

// File: rtl/sip_round_engine.sv
// Iterative SipRound engine: one half-round per clock, 0..15 rounds per job,
// valid/ready handshakes on both the job and result sides.
module sip_round_engine
  import sip_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ROT_A1 = ROT64_A1,
  parameter int unsigned ROT_A3 = ROT64_A3,
  parameter int unsigned ROT_B1 = ROT64_B1,
  parameter int unsigned ROT_B3 = ROT64_B3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_rounds,
  input  logic [WIDTH-1:0] v0_in,
  input  logic [WIDTH-1:0] v1_in,
  input  logic [WIDTH-1:0] v2_in,
  input  logic [WIDTH-1:0] v3_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] v0_out,
  output logic [WIDTH-1:0] v1_out,
  output logic [WIDTH-1:0] v2_out,
  output logic [WIDTH-1:0] v3_out,
  output logic             busy
);

  sip_state_t       state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] v0, v1, v2, v3;
  logic [WIDTH-1:0] a_v0, a_v1, a_v2, a_v3;
  logic [WIDTH-1:0] b_v0, b_v1, b_v2, b_v3;
  logic             accept;

  sip_half_round_comb #(.WIDTH(WIDTH), .ROT_1(ROT_A1), .ROT_3(ROT_A3)) u_half_a (
    .a(v0), .b(v1), .c(v2), .d(v3),
    .a_new(a_v0), .b_new(a_v1), .c_new(a_v2), .d_new(a_v3)
  );

  sip_half_round_comb #(.WIDTH(WIDTH), .ROT_1(ROT_B1), .ROT_3(ROT_B3)) u_half_b (
    .a(v2), .b(v1), .c(v0), .d(v3),
    .a_new(b_v2), .b_new(b_v1), .c_new(b_v0), .d_new(b_v3)
  );

  // A result handoff in DONE frees the engine on the same edge, so no bubble.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign v0_out = out_valid ? v0 : '0;
  assign v1_out = out_valid ? v1 : '0;
  assign v2_out = out_valid ? v2 : '0;
  assign v3_out = out_valid ? v3 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      v0        <= '0;
      v1        <= '0;
      v2        <= '0;
      v3        <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      v0  <= v0_in;
      v1  <= v1_in;
      v2  <= v2_in;
      v3  <= v3_in;
      cnt <= in_rounds;
      if (in_rounds == 4'd0) begin
        state     <= DONE;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else begin
        state     <= RUN_A;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end
    end else begin
      case (state)
        RUN_A: begin
          v0    <= a_v0;
          v1    <= a_v1;
          v2    <= a_v2;
          v3    <= a_v3;
          state <= RUN_B;
        end
        RUN_B: begin
          v0  <= b_v0;
          v1  <= b_v1;
          v2  <= b_v2;
          v3  <= b_v3;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= RUN_A;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
